// File: rtl/noc_router_pkg.sv
// Shared NoC router types and helpers: switch-allocator FSM states and the
// cyclic first-set search used for round-robin arbitration.
package noc_router_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    localparam int unsigned MAX_INPUTS = 32;

    function automatic int unsigned sel_width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the first set bit of req at or after ptr, wrapping at n; 0 when none is set.
    function automatic int unsigned rr_first_index(input logic [MAX_INPUTS-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
        int unsigned idx;
        logic        found;
        rr_first_index = 0;
        found          = 1'b0;
        for (int unsigned k = 0; k < MAX_INPUTS; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && req[idx[4:0]]) begin
                found          = 1'b1;
                rr_first_index = idx;
            end
        end
    endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Request/grant bundle between the input buffers/crossbar and one output's
// switch allocator. master = input-buffer side, slave = allocator.
interface noc_output_arbiter_if
    import noc_router_pkg::*;
#(
    parameter int NUM_INPUTS = 5,
    parameter int SEL_WIDTH  = sel_width_for(NUM_INPUTS)
);
    logic [NUM_INPUTS-1:0] valid_in;
    logic [NUM_INPUTS-1:0] is_tail_in;
    logic [NUM_INPUTS-1:0] turn_disable_in;
    logic [NUM_INPUTS-1:0] pop_out;
    logic [SEL_WIDTH-1:0]  sel_out;
    logic                  send_out;
    logic                  is_tail_out;

    modport master (
        output valid_in,
        output is_tail_in,
        output turn_disable_in,
        input  pop_out,
        input  sel_out,
        input  send_out,
        input  is_tail_out
    );

    modport slave (
        input  valid_in,
        input  is_tail_in,
        input  turn_disable_in,
        output pop_out,
        output sel_out,
        output send_out,
        output is_tail_out
    );

endinterface

// File: rtl/noc_rr_picker.sv
// Combinational cyclic priority picker: first eligible input at or after the
// round-robin pointer.
module noc_rr_picker
    import noc_router_pkg::*;
#(
    parameter int NUM_INPUTS = 5,
    parameter int SEL_WIDTH  = sel_width_for(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] eligible_i,
    input  logic [SEL_WIDTH-1:0]  ptr_i,
    output logic [SEL_WIDTH-1:0]  index_o,
    output logic                  found_o
);

    logic [MAX_INPUTS-1:0] req;

    always_comb begin
        req                   = '0;
        req[NUM_INPUTS-1:0]   = eligible_i;
        index_o               = SEL_WIDTH'(rr_first_index(req, 32'(ptr_i), NUM_INPUTS));
        found_o               = |eligible_i;
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output wormhole switch allocator: round-robin grant held head to tail,
// downstream credit tracking. Optional counters under NOC_OUTPUT_ARB_STATS_EN.
module noc_output_arbiter
    import noc_router_pkg::*;
#(
    parameter  int NUM_INPUTS        = 5,
    parameter  int FLIT_BUFFER_DEPTH = 1,
    localparam int SEL_WIDTH         = sel_width_for(NUM_INPUTS),
    localparam int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    noc_output_arbiter_if.slave     arb_if,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credit_count_out,
    output logic                    busy_out
`ifdef NOC_OUTPUT_ARB_STATS_EN
    ,
    output logic [31:0]             flit_count_out,
    output logic [31:0]             stall_count_out
`endif
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [SEL_WIDTH-1:0]    LAST_INPUT = SEL_WIDTH'(NUM_INPUTS - 1);

    arb_state_e              state_q, state_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [SEL_WIDTH-1:0]    rr_q, rr_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;

    logic [NUM_INPUTS-1:0]   eligible;
    logic [NUM_INPUTS-1:0]   pop;
    logic [SEL_WIDTH-1:0]    pick_idx;
    logic                    pick_found;
    logic                    has_credit;
    logic                    send;
    logic                    tail_send;

    // Turn-disabled inputs never enter arbitration; the mask only matters in IDLE.
    assign eligible   = arb_if.valid_in & ~arb_if.turn_disable_in;
    assign has_credit = (credits_q != '0);

    noc_rr_picker #(
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_picker (
        .eligible_i (eligible),
        .ptr_i      (rr_q),
        .index_o    (pick_idx),
        .found_o    (pick_found)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        send      = 1'b0;
        tail_send = 1'b0;
        pop       = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                // Other requesters are ignored until the locked packet's tail leaves.
                send      = arb_if.valid_in[sel_q] & has_credit;
                tail_send = send & arb_if.is_tail_in[sel_q];
                if (send) begin
                    pop[sel_q] = 1'b1;
                end
                if (tail_send) begin
                    state_d = ARB_IDLE;
                    rr_d    = (sel_q == LAST_INPUT) ? '0 : sel_q + SEL_WIDTH'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        if (send && !credit_in) begin
            credits_d = credits_q - CREDIT_WIDTH'(1);
        end else if (credit_in && !send && (credits_q != CREDIT_MAX)) begin
            credits_d = credits_q + CREDIT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q   <= ARB_IDLE;
            sel_q     <= '0;
            rr_q      <= '0;
            credits_q <= CREDIT_MAX;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            credits_q <= credits_d;
        end
    end

    assign arb_if.pop_out     = pop;
    assign arb_if.sel_out     = sel_q;
    assign arb_if.send_out    = send;
    assign arb_if.is_tail_out = tail_send;
    assign credit_count_out   = credits_q;
    assign busy_out           = (state_q == ARB_LOCKED);

`ifdef NOC_OUTPUT_ARB_STATS_EN
    logic [31:0] flit_cnt_q, flit_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // A stall is a locked cycle where the flit is waiting purely on downstream credit.
    always_comb begin
        flit_cnt_d  = flit_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (send) begin
            flit_cnt_d = flit_cnt_q + 32'd1;
        end
        if ((state_q == ARB_LOCKED) && arb_if.valid_in[sel_q] && !has_credit) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            flit_cnt_q  <= flit_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign flit_count_out  = flit_cnt_q;
    assign stall_count_out = stall_cnt_q;
`endif

    credit_overflow_a: assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
        !(credit_in && !send && (credits_q == CREDIT_MAX)));

    pop_onehot_a: assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
        $onehot0(pop));

    grant_hold_a: assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
        ((state_q == ARB_LOCKED) && !tail_send) |=> $stable(sel_q));

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Randomised and directed bench for noc_output_arbiter with an in-bench
// behavioural model of the packet-level allocation and credit rules.
module tb_noc_output_arbiter;

    localparam int N     = 5;
    localparam int DEPTH = 4;
    localparam int NEVER = 1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        creditIn;
    logic [2:0]  creditCount;
    logic        busy;
`ifdef NOC_OUTPUT_ARB_STATS_EN
    logic [31:0] flitCount;
    logic [31:0] stallCount;
`endif

    always #5 clk = ~clk;

    noc_output_arbiter_if #(.NUM_INPUTS(N)) arbIf ();

    noc_output_arbiter #(
        .NUM_INPUTS        (N),
        .FLIT_BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk_noc          (clk),
        .rst_noc_sync     (rst),
        .arb_if           (arbIf),
        .credit_in        (creditIn),
        .credit_count_out (creditCount),
        .busy_out         (busy)
`ifdef NOC_OUTPUT_ARB_STATS_EN
        ,
        .flit_count_out   (flitCount),
        .stall_count_out  (stallCount)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Upstream packet state and downstream credit return schedule.
    int rem [N];
    int creditDue [$];
    int creditDelay = 1;
    int cycleNo     = 0;
    bit randomMode  = 1'b0;
    bit randomDelay = 1'b0;
    bit bubbleEn    = 1'b0;
    bit rstReq      = 1'b1;
    logic [N-1:0] turnMask = '0;

    // Packet-level model of the output port.
    bit          modelValid = 1'b0;
    bit          mLocked;
    int          mOwner;
    int          mRr;
    int          mCredits;
    int unsigned mFlits;
    int unsigned mStalls;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        logic [N-1:0] v;
        logic [N-1:0] t;
        int pick;
        if (randomMode) begin
            rst = ($urandom_range(0, 299) == 0);
            arbIf.turn_disable_in = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = $urandom_range(1, 4);
            end
        end else begin
            rst = rstReq;
            arbIf.turn_disable_in = turnMask;
        end
        for (int i = 0; i < N; i++) begin
            v[i] = (rem[i] > 0) && !(bubbleEn && $urandom_range(0, 4) == 0);
            t[i] = (rem[i] == 1);
        end
        arbIf.valid_in   = v;
        arbIf.is_tail_in = t;
        pick = -1;
        foreach (creditDue[j]) begin
            if (pick < 0 && creditDue[j] <= cycleNo) pick = j;
        end
        creditIn = 1'b0;
        if (pick >= 0) begin
            creditDue.delete(pick);
            creditIn = 1'b1;
        end
    endtask

    task automatic compareAndStep();
        logic         expSend;
        logic         expTail;
        logic [N-1:0] expPop;
        int           idx;
        expSend = mLocked && arbIf.valid_in[mOwner] && (mCredits > 0);
        expTail = expSend && arbIf.is_tail_in[mOwner];
        expPop  = '0;
        if (expSend) expPop[mOwner] = 1'b1;
        if (modelValid) begin
            checkOutput("send_out", 32'(arbIf.send_out), 32'(expSend));
            checkOutput("pop_out", 32'(arbIf.pop_out), 32'(expPop));
            checkOutput("is_tail_out", 32'(arbIf.is_tail_out), 32'(expTail));
            checkOutput("sel_out", 32'(arbIf.sel_out), 32'(mOwner));
            checkOutput("busy_out", 32'(busy), 32'(mLocked));
            checkOutput("credit_count_out", 32'(creditCount), 32'(mCredits));
`ifdef NOC_OUTPUT_ARB_STATS_EN
            checkOutput("flit_count_out", flitCount, mFlits);
            checkOutput("stall_count_out", stallCount, mStalls);
`endif
        end
        if (rst) begin
            modelValid = 1'b1;
            mLocked    = 1'b0;
            mOwner     = 0;
            mRr        = 0;
            mCredits   = DEPTH;
            mFlits     = 0;
            mStalls    = 0;
            creditDue.delete();
            for (int i = 0; i < N; i++) rem[i] = 0;
        end else if (modelValid) begin
            if (expSend) mFlits++;
            if (mLocked && arbIf.valid_in[mOwner] && mCredits == 0) mStalls++;
            mCredits = mCredits + (creditIn ? 1 : 0) - (expSend ? 1 : 0);
            if (mCredits > DEPTH) mCredits = DEPTH;
            if (!mLocked) begin
                for (int k = 0; k < N; k++) begin
                    idx = (mRr + k) % N;
                    if (!mLocked && arbIf.valid_in[idx] && !arbIf.turn_disable_in[idx]) begin
                        mLocked = 1'b1;
                        mOwner  = idx;
                    end
                end
            end else if (expSend) begin
                rem[mOwner]--;
                creditDue.push_back(cycleNo + (randomDelay ? int'($urandom_range(1, 6)) : creditDelay));
                if (expTail) begin
                    mLocked = 1'b0;
                    mRr     = (mOwner + 1) % N;
                end
            end
        end
        cycleNo++;
    endtask

    // One clock cycle: drive after the rising edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        applyStimulus();
        @(negedge clk);
        compareAndStep();
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] expPattern;
        rst = 1'b1;
        creditIn = 1'b0;
        arbIf.valid_in = '0;
        arbIf.is_tail_in = '0;
        arbIf.turn_disable_in = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;

        // Reset state, then one idle cycle with nothing requested.
        step();
        step();
        rstReq = 1'b0;
        step();
        checkOutput("reset_credits", 32'(creditCount), 32'd4);
        checkOutput("reset_send", 32'(arbIf.send_out), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_sel", 32'(arbIf.sel_out), 32'd0);
        step();
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Two 3-flit packets on inputs 1 and 2 from rr pointer 0.
        creditDelay = 1;
        rem[1] = 3;
        rem[2] = 3;
        step();
        checkOutput("rr_grant_cycle_send", 32'(arbIf.send_out), 32'd0);
        step();
        checkOutput("rr_first_sel", 32'(arbIf.sel_out), 32'd1);
        checkOutput("rr_first_send", 32'(arbIf.send_out), 32'd1);
        checkOutput("rr_first_pop", 32'(arbIf.pop_out), 32'h02);
        step();
        step();
        checkOutput("rr_tail", 32'(arbIf.is_tail_out), 32'd1);
        step();
        checkOutput("rr_gap_busy", 32'(busy), 32'd0);
        checkOutput("rr_gap_credits", 32'(creditCount), 32'd3);
        step();
        checkOutput("rr_second_sel", 32'(arbIf.sel_out), 32'd2);
        checkOutput("rr_second_send", 32'(arbIf.send_out), 32'd1);
        repeat (4) step();

        // Withhold three credits so one remains, then return each two cycles after send.
        creditDelay = NEVER;
        rem[0] = 3;
        repeat (5) step();
        creditDelay = 2;
        rem[3] = 3;
        step();
        expPattern = 7'b1001001;
        for (int k = 0; k < 7; k++) begin
            step();
            checkOutput("one_credit_send", 32'(arbIf.send_out), 32'(expPattern[6 - k]));
            checkOutput("one_credit_cap", 32'(creditCount <= 3'd1), 32'd1);
        end
        repeat (3) step();

        // Stall a packet on zero credits, then reset it away.
        creditDelay = NEVER;
        rem[4] = 5;
        step();
        step();
        step();
        checkOutput("stall_busy", 32'(busy), 32'd1);
        checkOutput("stall_credits", 32'(creditCount), 32'd0);
        checkOutput("stall_send", 32'(arbIf.send_out), 32'd0);
        rstReq = 1'b1;
        step();
        rstReq = 1'b0;
        step();
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_credits", 32'(creditCount), 32'd4);
`ifdef NOC_OUTPUT_ARB_STATS_EN
        checkOutput("midreset_flits", flitCount, 32'd0);
        checkOutput("midreset_stalls", stallCount, 32'd0);
`endif

        // Simultaneous send and credit return at two credits.
        creditDelay = NEVER;
        rem[0] = 1;
        repeat (3) step();
        creditDelay = 1;
        rem[1] = 3;
        step();
        step();
        checkOutput("both_pre_credits", 32'(creditCount), 32'd3);
        step();
        checkOutput("both_credits", 32'(creditCount), 32'd2);
        checkOutput("both_credit_in", 32'(creditIn), 32'd1);
        checkOutput("both_send", 32'(arbIf.send_out), 32'd1);
        step();
        checkOutput("both_hold_credits", 32'(creditCount), 32'd2);
        step();
        checkOutput("both_after_credits", 32'(creditCount), 32'd2);
        step();
        checkOutput("both_return_credits", 32'(creditCount), 32'd3);

        // Turn-disabled requester is never granted; an enabled one is.
        turnMask = 5'b00010;
        rem[1] = 4;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput("turn_block_busy", 32'(busy), 32'd0);
        end
        rem[0] = 2;
        step();
        step();
        checkOutput("turn_alt_busy", 32'(busy), 32'd1);
        checkOutput("turn_alt_sel", 32'(arbIf.sel_out), 32'd0);
        repeat (3) step();
        turnMask = '0;

        // Random traffic with bubbles, random turn masks, credit delays and resets.
        randomMode  = 1'b1;
        randomDelay = 1'b1;
        bubbleEn    = 1'b1;
        repeat (3000) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
